// File: rtl/histogram_engine.sv
// Per-frame pixel histogram: clear bins, accumulate saturating counts, then read back.
// Optional peak tracking is enabled with `define HISTOGRAM_PEAK_TRACK_EN.
module histogram_engine #(
    parameter int PIX_W = 6,
    parameter int CNT_W = 12,
    parameter int TOT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_value,
    input  logic             frame_end,
    output logic             pix_ready,
    output logic             busy,
    output logic             done,
    input  logic [PIX_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic [TOT_W-1:0] total_count,
    output logic             sat_flag,
    output logic [PIX_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count,
    output logic [2:0]       dbg_state_o
);
    localparam int NUM_BINS = 2 ** PIX_W;
    localparam logic [CNT_W-1:0] BIN_MAX  = '1;
    localparam logic [TOT_W-1:0] TOT_MAX  = '1;
    localparam logic [PIX_W-1:0] LAST_BIN = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] clr_idx_q, clr_idx_d;
    logic             accept;

    logic             s1_valid_q;
    logic [PIX_W-1:0] s1_addr_q;
    logic             s2_valid_q;
    logic [PIX_W-1:0] s2_addr_q;
    logic [CNT_W-1:0] s2_data_q;
    logic [CNT_W-1:0] s1_cur, s1_next;
    logic             s1_sat;

    logic [TOT_W-1:0] total_q, total_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] rd_data_q;

    logic [CNT_W-1:0] mem [NUM_BINS];

    // Handshake: a pixel is transferred on a rising edge where pix_valid && pix_ready;
    // pix_ready depends only on state, never on pix_valid, and unaccepted pixels are dropped.
    assign accept      = pix_valid & pix_ready;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = '0;
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_BIN) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                if (frame_end) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // S2 commits on this same edge, so an empty S1 means the pipe is done.
                if (!s1_valid_q) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // S2 has not written its value yet, so a matching S1 must take it instead of memory.
    always_comb begin
        s1_cur  = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_data_q : mem[s1_addr_q];
        s1_sat  = s1_valid_q && (s1_cur == BIN_MAX);
        s1_next = (s1_cur == BIN_MAX) ? BIN_MAX : s1_cur + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) s1_addr_q <= pix_value;
            s2_valid_q <= s1_valid_q;
            s2_addr_q  <= s1_addr_q;
            s2_data_q  <= s1_next;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (s2_valid_q) begin
            mem[s2_addr_q] <= s2_data_q;
        end
    end

    always_comb begin
        total_d = total_q;
        sat_d   = sat_q;
        if (state_q == S_CLEAR) begin
            total_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (accept) begin
                if (total_q == TOT_MAX) sat_d = 1'b1;
                else                    total_d = total_q + 1'b1;
            end
            if (s1_sat) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q   <= '0;
            sat_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            total_q   <= total_d;
            sat_q     <= sat_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    assign total_count = total_q;
    assign sat_flag    = sat_q;
    assign rd_data     = rd_data_q;

`ifdef HISTOGRAM_PEAK_TRACK_EN
    logic [PIX_W-1:0] peak_bin_q;
    logic [CNT_W-1:0] peak_count_q;

    // Strict compare: on a tie the bin that reached the value first is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_bin_q   <= '0;
            peak_count_q <= '0;
        end else if (state_q == S_CLEAR) begin
            peak_bin_q   <= '0;
            peak_count_q <= '0;
        end else if (s2_valid_q && (s2_data_q > peak_count_q)) begin
            peak_bin_q   <= s2_addr_q;
            peak_count_q <= s2_data_q;
        end
    end

    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;
`else
    assign peak_bin   = '0;
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_histogram_engine.sv
// Self-checking bench for histogram_engine; frames are checked bin-by-bin against a counting model.
module tb_histogram_engine;
  localparam int PIX_W    = 6;
  localparam int CNT_W    = 4;
  localparam int TOT_W    = 6;
  localparam int NUM_BINS = 64;
  localparam int BIN_MAX  = 15;
  localparam int TOT_MAX  = 63;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_value;
  logic             frame_end;
  logic             pix_ready;
  logic             busy;
  logic             done;
  logic [PIX_W-1:0] rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic [TOT_W-1:0] total_count;
  logic             sat_flag;
  logic [PIX_W-1:0] peak_bin;
  logic [CNT_W-1:0] peak_count;
  logic [2:0]       dbg_state;

  histogram_engine #(.PIX_W(PIX_W), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_value(pix_value),
    .frame_end(frame_end), .pix_ready(pix_ready), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .total_count(total_count), .sat_flag(sat_flag),
    .peak_bin(peak_bin), .peak_count(peak_count), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  int               frame_q[$];
  logic [CNT_W-1:0] exp_q[$];
  int               exp_bins[NUM_BINS];
  int               exp_total;
  int               exp_sat;
  int               exp_peak_bin;
  int               exp_peak_cnt;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: count occurrences with clamping, remember the first bin to reach a new maximum.
  function automatic void build_model();
    int p;
    for (int b = 0; b < NUM_BINS; b++) exp_bins[b] = 0;
    exp_total = 0;
    exp_sat = 0;
    exp_peak_bin = 0;
    exp_peak_cnt = 0;
    foreach (frame_q[i]) begin
      p = frame_q[i];
      if (exp_bins[p] == BIN_MAX) exp_sat = 1;
      else exp_bins[p] = exp_bins[p] + 1;
      if (exp_total == TOT_MAX) exp_sat = 1;
      else exp_total = exp_total + 1;
`ifdef HISTOGRAM_PEAK_TRACK_EN
      if (exp_bins[p] > exp_peak_cnt) begin
        exp_peak_cnt = exp_bins[p];
        exp_peak_bin = p;
      end
`endif
    end
  endfunction

  // driver: start a frame, wait for clearing (with junk on the pixel port), send frame_q, wait for done
  task automatic run_frame(input bit gaps, output int clr_cycles, output int drain_cycles);
    start = 1'b1;
    pix_valid = 1'($urandom_range(0, 1));
    pix_value = PIX_W'($urandom_range(0, NUM_BINS - 1));
    frame_end = 1'b0;
    cycle();
    start = 1'b0;
    clr_cycles = 1;
    while (!pix_ready && clr_cycles < 200) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_value = PIX_W'($urandom_range(0, NUM_BINS - 1));
      frame_end = 1'($urandom_range(0, 1));
      cycle();
      clr_cycles++;
    end
    n_checks++;
    if (pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_timeout: pix_ready=%b after %0d cycles, required 1", pix_ready, clr_cycles);
    end
    if (frame_q.size() == 0) begin
      pix_valid = 1'b0;
      frame_end = 1'b1;
      cycle();
    end else begin
      foreach (frame_q[i]) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          pix_valid = 1'b0;
          pix_value = PIX_W'($urandom_range(0, NUM_BINS - 1));
          frame_end = 1'b0;
          start = 1'($urandom_range(0, 1));
          cycle();
          start = 1'b0;
        end
        pix_valid = 1'b1;
        pix_value = PIX_W'(frame_q[i]);
        frame_end = (i == frame_q.size() - 1);
        cycle();
      end
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
    drain_cycles = 1;
    while (!done && drain_cycles < 20) begin
      cycle();
      drain_cycles++;
    end
  endtask

  // compare every bin and the frame summary outputs against the model
  task automatic check_frame(input string name, input int drain_cycles);
    logic [CNT_W-1:0] exp_v;
    build_model();
    n_checks++;
    if (done !== 1'b1 || drain_cycles > 3) begin
      n_fail++;
      $display("FAIL %s_done_latency: done=%b after %0d cycles, required 1 within 3", name, done, drain_cycles);
    end
    for (int a = 0; a < NUM_BINS; a++) exp_q.push_back(CNT_W'(exp_bins[a]));
    for (int a = 0; a < NUM_BINS; a++) begin
      rd_addr = PIX_W'(a);
      cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd_data !== exp_v) begin
        n_fail++;
        $display("FAIL %s_bin%0d: got %0d expected %0d", name, a, rd_data, exp_v);
      end
    end
    n_checks++;
    if (total_count !== TOT_W'(exp_total)) begin
      n_fail++;
      $display("FAIL %s_total: got %0d expected %0d", name, total_count, exp_total);
    end
    n_checks++;
    if (sat_flag !== 1'(exp_sat)) begin
      n_fail++;
      $display("FAIL %s_sat: got %b expected %0d", name, sat_flag, exp_sat);
    end
    n_checks++;
    if (peak_bin !== PIX_W'(exp_peak_bin) || peak_count !== CNT_W'(exp_peak_cnt)) begin
      n_fail++;
      $display("FAIL %s_peak: got bin %0d cnt %0d expected bin %0d cnt %0d",
               name, peak_bin, peak_count, exp_peak_bin, exp_peak_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_flags: got busy %b ready %b expected 0 0", name, busy, pix_ready);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({pix_ready, busy, done, sat_flag} !== 4'b0 || rd_data !== '0 || total_count !== '0 ||
        peak_bin !== '0 || peak_count !== '0) begin
      n_fail++;
      $display("FAIL %s: got ready %b busy %b done %b sat %b rd %0d total %0d peak %0d/%0d expected all 0",
               name, pix_ready, busy, done, sat_flag, rd_data, total_count, peak_bin, peak_count);
    end
  endtask

  task automatic test_reset();
    int clr_c, drn_c;
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_value = '0;
    frame_end = 1'b0;
    rd_addr = '0;
    cycle();
    cycle();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    cycle();
    frame_q.delete();
    run_frame(1'b0, clr_c, drn_c);
    n_checks++;
    if (clr_c != NUM_BINS + 1) begin
      n_fail++;
      $display("FAIL clear_length: got %0d cycles expected %0d", clr_c, NUM_BINS + 1);
    end
    check_frame("empty", drn_c);
  endtask

  task automatic test_back_to_back();
    int clr_c, drn_c;
    frame_q = '{5, 5, 5, 38};
    run_frame(1'b0, clr_c, drn_c);
    check_frame("b2b", drn_c);
  endtask

  task automatic test_alternating();
    int clr_c, drn_c;
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back((i % 2 == 0) ? 0 : 39);
    run_frame(1'b0, clr_c, drn_c);
    check_frame("alt", drn_c);
  endtask

  task automatic test_bin_saturation();
    int clr_c, drn_c;
    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back(34);
    run_frame(1'b0, clr_c, drn_c);
    check_frame("bin_sat", drn_c);
  endtask

  task automatic test_total_saturation();
    int clr_c, drn_c;
    frame_q.delete();
    for (int i = 0; i < 70; i++) frame_q.push_back(i % NUM_BINS);
    run_frame(1'b1, clr_c, drn_c);
    check_frame("tot_sat", drn_c);
  endtask

  task automatic test_ignored_inputs();
    logic [TOT_W-1:0] tot_before;
    tot_before = total_count;
    pix_valid = 1'b1;
    pix_value = 6'd3;
    frame_end = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    pix_valid = 1'b0;
    frame_end = 1'b0;
    cycle();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || total_count !== tot_before) begin
      n_fail++;
      $display("FAIL ignored_in_done: got done %b busy %b total %0d expected 1 0 %0d",
               done, busy, total_count, tot_before);
    end
  endtask

  task automatic test_mid_reset();
    int clr_c, drn_c;
    int n;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (!pix_ready && n < 200) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_value = PIX_W'($urandom_range(0, NUM_BINS - 1));
      cycle();
    end
    #3 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    pix_valid = 1'b0;
    cycle();
    frame_q = '{2, 2, 2};
    run_frame(1'b0, clr_c, drn_c);
    check_frame("after_rst", drn_c);
  endtask

  task automatic test_peak();
    int clr_c, drn_c;
    frame_q = '{7, 9, 9, 7, 7};
    run_frame(1'b0, clr_c, drn_c);
    check_frame("peak", drn_c);
  endtask

  task automatic test_random();
    int clr_c, drn_c;
    int len, hi;
    for (int f = 0; f < 6; f++) begin
      frame_q.delete();
      len = $urandom_range(1, 60);
      hi = (f % 2 == 0) ? 3 : NUM_BINS - 1;
      for (int i = 0; i < len; i++) frame_q.push_back($urandom_range(0, hi));
      run_frame(1'b1, clr_c, drn_c);
      check_frame($sformatf("rand%0d", f), drn_c);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alternating();
    test_bin_saturation();
    test_total_saturation();
    test_ignored_inputs();
    test_mid_reset();
    test_peak();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
